// File: rtl/ccff_loader_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the
// configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int DEF_CHAIN_LEN = 8;
  localparam int DEF_DATA_W    = 8;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and presents it bit 0 first on a registered
// head output; word_last flags the final bit of the current word.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              i_load,
  input  logic [0:DATA_W-1] i_data,
  input  logic              i_shift,
  input  logic              i_adv_head,
  output logic              o_head,
  output logic              o_word_last
);

  localparam int WL_W = cnt_width(DATA_W);

  logic [0:DATA_W-1] r_sreg;
  logic [WL_W-1:0]   r_word_left;
  logic              r_head;
  logic [0:DATA_W-1] w_sreg_next;

  // Index 0 is the MSB of an ascending vector, so a left shift brings bit 1 to bit 0.
  assign w_sreg_next = r_sreg << 1;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_sreg      <= '0;
      r_word_left <= '0;
      r_head      <= 1'b0;
    end else if (i_load) begin
      r_sreg      <= i_data;
      r_word_left <= WL_W'(DATA_W);
      r_head      <= i_data[0];
    end else if (i_shift) begin
      r_sreg      <= w_sreg_next;
      r_word_left <= r_word_left - WL_W'(1);
      if (i_adv_head) r_head <= w_sreg_next[0];
    end
  end

  assign o_head      = r_head;
  assign o_word_last = (r_word_left == WL_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words onto a configuration chain with a registered
// shift-enable, and counts 1s returning on the chain tail.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_LOAD  | in_ready high, waiting for the next word
//   ST_SHIFT | one chain bit shifted per cycle (shift_en high)
//   ST_DONE  | one-cycle done pulse, then back to idle
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [0:DATA_W-1] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [0:0]        ccff_head,
  output logic              ccff_shift_en,
  input  logic [0:0]        ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [0:CNT_W-1]  tail_ones
);

  state_e           r_state;
  logic [CNT_W-1:0] r_bits_left;
  logic [CNT_W-1:0] r_tail_ones;
  logic             r_shift_en;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;

  logic w_load;
  logic w_shift;
  logic w_last_bit;
  logic w_word_last;
  logic w_adv_head;
  logic w_head;

  assign w_load     = (r_state == ST_LOAD) && in_valid && !abort;
  assign w_shift    = (r_state == ST_SHIFT) && !abort;
  assign w_last_bit = (r_bits_left == CNT_W'(1));
  // The head keeps its last bit whenever shifting pauses (bubble, stall, done).
  assign w_adv_head = w_shift && !w_last_bit && !w_word_last;

  ccff_word_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .i_load      (w_load),
    .i_data      (in_data),
    .i_shift     (w_shift),
    .i_adv_head  (w_adv_head),
    .o_head      (w_head),
    .o_word_last (w_word_last)
  );

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state     <= ST_IDLE;
      r_bits_left <= '0;
      r_shift_en  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state    <= ST_IDLE;
      r_shift_en <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_LOAD;
            r_bits_left <= CNT_W'(CHAIN_LEN);
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_state    <= ST_SHIFT;
            r_in_ready <= 1'b0;
            r_shift_en <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_bits_left <= r_bits_left - CNT_W'(1);
          if (w_last_bit) begin
            r_state    <= ST_DONE;
            r_shift_en <= 1'b0;
            r_done     <= 1'b1;
          end else if (w_word_last) begin
            r_state    <= ST_LOAD;
            r_shift_en <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tail monitor: cleared when a load starts, kept across abort.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_tail_ones <= '0;
    end else if ((r_state == ST_IDLE) && start && !abort) begin
      r_tail_ones <= '0;
    end else if (r_shift_en && ccff_tail[0] && (r_tail_ones != CNT_W'(CHAIN_LEN))) begin
      r_tail_ones <= r_tail_ones + CNT_W'(1);
    end
  end

  assign in_ready      = r_in_ready;
  assign ccff_head     = w_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign tail_ones     = r_tail_ones;

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Configuration-chain driver that sits directly upstream of the IO grid tiles. It accepts bitstream words over a valid/ready handshake and serializes them LSB-index-first onto the tile's `ccff_head`. It produces the shift-enable that gates the chain's programming clock. It also monitors the chain's `ccff_tail` so a load can be checked by a second pass.

## Interface
- `CHAIN_LEN`, default 8: total configuration bits in the downstream chain; must be ≥1.
- `DATA_W`, default 8: bits per bitstream word; must be ≥1.
- `CNT_W`, default $clog2(CHAIN_LEN+1): width of bit counters.
- `prog_clk` input 1: programming clock; all state is updated on its rising edge.
- `prog_reset` input 1: reset; asynchronous, active-high.
- `start` input 1: single-cycle pulse that begins a load; ignored unless in IDLE.
- `abort` input 1: pulse that terminates the load and returns the block to IDLE.
- `in_data` input [0:DATA_W-1]: bitstream word; bit 0 is shifted first.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the loader accepts a word on this edge when `in_valid` is also high.
- `ccff_head` output [0:0]: serial configuration bit, registered.
- `ccff_shift_en` output 1: registered; when high, the chain shifts at the next `prog_clk` edge.
- `ccff_tail` input [0:0]: chain output bit.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when all `CHAIN_LEN` bits have been shifted.
- `tail_ones` output [0:CNT_W-1]: count of 1s sampled on `ccff_tail` during the current or last load.

## Operation
- States:
  - IDLE: `start` → LOAD; clears `bits_left` to `CHAIN_LEN` and `tail_ones` to 0.
  - LOAD: `in_ready`=1. A handshake captures `in_data` into the shift register, sets `word_left`=DATA_W, and moves to SHIFT.
  - SHIFT: each cycle drives `ccff_head`=`sreg[0]` with `ccff_shift_en`=1, shifts the register, and decrements `bits_left` and `word_left`.
    - `bits_left` reaching 0 → DONE; any remaining word bits are discarded.
    - `word_left` reaching 0 with `bits_left`>0 → LOAD.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Tail monitor: on every edge where `ccff_shift_en`=1, sample `ccff_tail`; if it is 1, increment `tail_ones`. `tail_ones` saturates at `CHAIN_LEN`.
- In LOAD with `in_valid`=0 the loader stalls: `ccff_shift_en`=0 and `ccff_head` holds its last value.
- `abort` has priority over every transition. The next state is IDLE, `ccff_shift_en` is 0 on the following cycle, no `done` pulse is issued, and `tail_ones` holds its value.
- `start` while `busy` is ignored.
- `in_valid` outside LOAD is ignored, with no acceptance.

## Timing
- Reset values: IDLE, `in_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `tail_ones`=0.
- `start` sampled high at edge t:
  - LOAD and `in_ready`=1 from t+1.
  - If `in_valid` is already high at t+1, the word is accepted at edge t+1.
  - First `ccff_shift_en`=1 cycle is t+2.
- Word accepted at edge k: `ccff_shift_en`=1 during cycles k+1 … k+min(DATA_W, `bits_left`). The loader returns to LOAD the following cycle, giving one bubble cycle per word.
- Total active shift cycles per load is exactly `CHAIN_LEN`.
- `done` asserts in the cycle after the final shift cycle; `busy` drops the cycle after `done`.
- Asynchronous reset mid-load forces all outputs to their reset values immediately, with no partial `done` pulse.

## Structure
- Shared package `ccff_loader_pkg` holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - the default `CHAIN_LEN`/`DATA_W` constants;
  - the count-width helper function.
- One natural sub-module: `ccff_word_serializer`, which holds the shift register, `word_left` counter and `ccff_head` register. The top level keeps the FSM, `bits_left` and the tail monitor.

## Test plan
- Single word: CHAIN_LEN=8, DATA_W=8, `in_data`={1,0,1,1,0,0,1,0} → `ccff_head`=1,0,1,1,0,0,1,0 over 8 consecutive `ccff_shift_en` cycles; `done` asserts 1 cycle after the last shift; `busy` then drops.
- Partial last word: CHAIN_LEN=12, DATA_W=8, two words → 8 shifts, 1 bubble, 4 shifts; the second word's bits 4–7 never appear; exactly 12 shift cycles.
- Back-pressure: `in_valid` held low for 5 cycles in LOAD → `ccff_shift_en`=0 and `ccff_head` stable throughout; the sequence resumes intact.
- Loopback readback: 8-flop chain model, first load 8'b11100000 pattern (three 1s), second load all-zero → `tail_ones`=3 after the second `done`.
- Abort after 3 shifts → IDLE next cycle, no `done`, `ccff_shift_en`=0; `start` then produces a full fresh 8-bit load.
- Reset asserted during SHIFT → all outputs at reset values asynchronously; `start` during `busy` has no effect.
